// File: rtl/mem_pkg.sv
// Shared types and constants for the main memory controller.
package mem_pkg;

    localparam int ADDR_W      = 13;
    localparam int LINE_BYTES  = 4;
    localparam int DATA_W      = 8;
    localparam int LINE_W      = LINE_BYTES * DATA_W;
    localparam int LINE_ADDR_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_RWAIT  = 3'd2,
        ST_RBURST = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/mem_byte_ram.sv
// 8192 x 8 single-port backing store, synchronous read, contents survive reset.
module mem_byte_ram
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1] = '{default: '0};
    logic [DATA_W-1:0] r_rdata = '0;

    // Write on enable; registered read returns the old contents on a collision.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/main_mem_ctrl.sv
// Main memory controller: byte write-through buffer drained ahead of
// 4-byte line refills from a single-port byte RAM.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | nothing in flight; picks drain (priority) or refill
//   ST_DRAIN  | one buffered write per cycle into RAM, FIFO order
//   ST_RWAIT  | RD_LAT-cycle wait before the burst (skipped if 0)
//   ST_RBURST | beats 0..3 issue line bytes, beats 1..4 capture them
//   ST_RESP   | one-cycle rvalid pulse with the assembled line
module main_mem_ctrl
    import mem_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rreq_from_cache,
    input  logic [ADDR_W-1:0] raddr_from_cache,
    input  logic              wreq_from_cache,
    input  logic [ADDR_W-1:0] waddr_from_cache,
    input  logic [DATA_W-1:0] wdata_from_cache,
    output logic [LINE_W-1:0] rdata_to_cache,
    output logic              rvalid_to_cache,
    output logic              busy,
    output logic              wr_overflow
);

    localparam int              PTR_W    = $clog2(WBUF_DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);
    localparam logic [3:0]      LAT_LOAD = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_start_rd;

    wbuf_entry_t            r_wbuf [WBUF_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_enq;
    logic                   w_deq;
    wbuf_entry_t            w_head;
    logic                   r_overflow;

    logic [LINE_ADDR_W-1:0] r_line;
    logic [3:0]             r_lat_cnt;
    logic [2:0]             r_beat;
    logic [LINE_W-1:0]      r_fill;
    logic [LINE_W-1:0]      r_rdata;

    logic                   w_ram_we;
    logic [ADDR_W-1:0]      w_ram_addr;
    logic [DATA_W-1:0]      w_ram_wdata;
    logic [DATA_W-1:0]      w_ram_rdata;
    logic                   w_unused;

    assign w_unused     = ^raddr_from_cache[1:0];

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_deq        = (r_state == ST_DRAIN) && !w_empty;
    // A full buffer still takes a write in a cycle that frees a slot.
    assign w_enq        = wreq_from_cache && (!w_full || w_deq);
    assign w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    assign w_head       = r_wbuf[r_rd_ptr];

    // Buffer pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            if (wreq_from_cache && !w_enq) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Buffer storage; stale entries after reset are unreachable.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wbuf[r_wr_ptr] <= '{addr: waddr_from_cache, data: wdata_from_cache};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. When the last pending write drains and a refill is
    // already waiting, the refill starts straight away instead of spending
    // an extra cycle in IDLE; with rreq low the FSM returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        w_start_rd   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty || wreq_from_cache) begin
                    w_state_next = ST_DRAIN;
                end else if (rreq_from_cache) begin
                    w_start_rd = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_count_next == '0) begin
                    if (rreq_from_cache) begin
                        w_start_rd = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_RWAIT: begin
                if (r_lat_cnt == 4'd0) begin
                    w_state_next = ST_RBURST;
                end
            end
            ST_RBURST: begin
                if (r_beat == 3'd4) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_start_rd) begin
            w_state_next = (RD_LAT == 0) ? ST_RBURST : ST_RWAIT;
        end
    end

    // Refill datapath: line latch, wait down-counter, beat count, lane capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line    <= '0;
            r_lat_cnt <= '0;
            r_beat    <= '0;
            r_fill    <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_start_rd) begin
                r_line    <= raddr_from_cache[ADDR_W-1:2];
                r_lat_cnt <= LAT_LOAD;
                r_beat    <= '0;
            end
            if ((r_state == ST_RWAIT) && (r_lat_cnt != 4'd0)) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if (r_state == ST_RBURST) begin
                r_beat <= r_beat + 3'd1;
                case (r_beat)
                    3'd1: r_fill[7:0]   <= w_ram_rdata;
                    3'd2: r_fill[15:8]  <= w_ram_rdata;
                    3'd3: r_fill[23:16] <= w_ram_rdata;
                    3'd4: begin
                        r_fill[31:24] <= w_ram_rdata;
                        r_rdata       <= {w_ram_rdata, r_fill[23:0]};
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM port steering: drain writes win, otherwise burst addresses.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = w_head.addr;
        w_ram_wdata = w_head.data;
        if (w_deq) begin
            w_ram_we = 1'b1;
        end else if (r_state == ST_RBURST) begin
            w_ram_addr = {r_line, r_beat[1:0]};
        end
    end

    mem_byte_ram u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign rdata_to_cache  = r_rdata;
    assign rvalid_to_cache = (r_state == ST_RESP);
    assign busy            = (r_state != ST_IDLE) || !w_empty;
    assign wr_overflow     = r_overflow;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: default build (RD_LAT=2) plus an RD_LAT=0 build.
module tb_main_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;

    logic        rreq_a, wreq_a;
    logic [12:0] raddr_a, waddr_a;
    logic [7:0]  wdata_a;
    logic [31:0] rdata_a;
    logic        rvalid_a, busy_a, ovf_a;

    logic        rreq_b, wreq_b;
    logic [12:0] raddr_b, waddr_b;
    logic [7:0]  wdata_b;
    logic [31:0] rdata_b;
    logic        rvalid_b, busy_b, ovf_b;

    int n_total = 0;
    int n_bad   = 0;

    main_mem_ctrl #(.RD_LAT(2), .WBUF_DEPTH(4)) dut_a (
        .clk              (clk),
        .reset            (reset),
        .rreq_from_cache  (rreq_a),
        .raddr_from_cache (raddr_a),
        .wreq_from_cache  (wreq_a),
        .waddr_from_cache (waddr_a),
        .wdata_from_cache (wdata_a),
        .rdata_to_cache   (rdata_a),
        .rvalid_to_cache  (rvalid_a),
        .busy             (busy_a),
        .wr_overflow      (ovf_a)
    );

    main_mem_ctrl #(.RD_LAT(0), .WBUF_DEPTH(4)) dut_b (
        .clk              (clk),
        .reset            (reset),
        .rreq_from_cache  (rreq_b),
        .raddr_from_cache (raddr_b),
        .wreq_from_cache  (wreq_b),
        .waddr_from_cache (waddr_b),
        .wdata_from_cache (wdata_b),
        .rdata_to_cache   (rdata_b),
        .rvalid_to_cache  (rvalid_b),
        .busy             (busy_b),
        .wr_overflow      (ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a && n < 60) begin
            tick();
            n++;
        end
        if (busy_a) chk("idle_wait_timeout", 32'(busy_a), 32'd0);
    endtask

    // Issue a refill on one DUT; lat is the cycle index of rvalid after the sampling edge.
    task automatic do_read(input bit sel, input logic [12:0] addr,
                           output int lat, output logic [31:0] data);
        lat = -1;
        if (sel) begin rreq_b = 1'b1; raddr_b = addr; end
        else     begin rreq_a = 1'b1; raddr_a = addr; end
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (sel ? rvalid_b : rvalid_a) begin
                lat = n;
                break;
            end
        end
        rreq_a = 1'b0;
        rreq_b = 1'b0;
        data = sel ? rdata_b : rdata_a;
    endtask

    initial begin
        int          lat;
        logic [31:0] d;

        reset = 1'b1;
        rreq_a = 0; wreq_a = 0; raddr_a = '0; waddr_a = '0; wdata_a = '0;
        rreq_b = 0; wreq_b = 0; raddr_b = '0; waddr_b = '0; wdata_b = '0;
        tick(); tick();
        chk("rst_rvalid", 32'(rvalid_a), 32'd0);
        chk("rst_rdata",  rdata_a, 32'h0);
        chk("rst_busy",   32'(busy_a), 32'd0);
        chk("rst_ovf",    32'(ovf_a), 32'd0);
        reset = 1'b0;
        tick();

        // Fresh RAM reads as zero; rvalid 8 cycles after the request, one cycle wide.
        do_read(1'b0, 13'h0005, lat, d);
        chk("rd0_lat",  32'(lat), 32'd8);
        chk("rd0_data", d, 32'h0);
        tick();
        chk("rd0_pulse", 32'(rvalid_a), 32'd0);

        // Four byte writes then a refill of that line.
        for (int k = 0; k < 4; k++) begin
            wreq_a  = 1'b1;
            waddr_a = 13'h0100 + 13'(k);
            wdata_a = 8'(8'h11 * (k + 1));
            tick();
            if (k == 0) chk("wr_busy", 32'(busy_a), 32'd1);
        end
        wreq_a = 1'b0;
        wait_idle_a();
        do_read(1'b0, 13'h0102, lat, d);
        chk("rd1_lat",  32'(lat), 32'd8);
        chk("rd1_data", d, 32'h44332211);
        tick(); tick(); tick();
        chk("rd1_hold", rdata_a, 32'h44332211);

        // Read and write together in IDLE: drain first, read sees the new byte.
        rreq_a = 1'b1; raddr_a = 13'h0200;
        wreq_a = 1'b1; waddr_a = 13'h0203; wdata_a = 8'hAB;
        tick();
        wreq_a = 1'b0;
        lat = -1;
        for (int n = 2; n <= 40; n++) begin
            tick();
            if (rvalid_a) begin lat = n; break; end
        end
        rreq_a = 1'b0;
        chk("rw_lat",  32'(lat), 32'd9);
        chk("rw_data", rdata_a, 32'hAB000000);
        wait_idle_a();

        // Five writes while a refill is in flight: the fifth is dropped.
        rreq_a = 1'b1; raddr_a = 13'h0100;
        tick(); tick(); tick();
        for (int k = 0; k < 5; k++) begin
            wreq_a  = 1'b1;
            waddr_a = 13'h0300 + 13'(k);
            wdata_a = 8'hA0 + 8'(k);
            tick();
        end
        wreq_a = 1'b0; rreq_a = 1'b0;
        chk("ov_rvalid", 32'(rvalid_a), 32'd1);
        chk("ov_rdata",  rdata_a, 32'h44332211);
        chk("ov_flag",   32'(ovf_a), 32'd1);
        tick();
        tick();
        // First drain cycle with a full buffer: this write must be accepted.
        wreq_a = 1'b1; waddr_a = 13'h0305; wdata_a = 8'hA5;
        tick();
        wreq_a = 1'b0;
        wait_idle_a();
        chk("ov_sticky", 32'(ovf_a), 32'd1);
        do_read(1'b0, 13'h0300, lat, d);
        chk("ov_line0", d, 32'hA3A2A1A0);
        do_read(1'b0, 13'h0304, lat, d);
        chk("ov_line1", d, 32'h0000A500);
        tick();

        // Reset in the middle of a burst.
        rreq_a = 1'b1; raddr_a = 13'h0200;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_rdata",  rdata_a, 32'h0);
        chk("mid_rst_rvalid", 32'(rvalid_a), 32'd0);
        chk("mid_rst_busy",   32'(busy_a), 32'd0);
        chk("mid_rst_ovf",    32'(ovf_a), 32'd0);
        rreq_a = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        do_read(1'b0, 13'h0200, lat, d);
        chk("post_rst_lat",  32'(lat), 32'd8);
        chk("post_rst_data", d, 32'hAB000000);
        do_read(1'b0, 13'h0101, lat, d);
        chk("post_rst_line", d, 32'h44332211);
        tick();

        // Zero-latency build.
        do_read(1'b1, 13'h0005, lat, d);
        chk("lat0_lat",  32'(lat), 32'd6);
        chk("lat0_data", d, 32'h0);
        tick();
        chk("lat0_pulse", 32'(rvalid_b), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
